// File: rtl/iter_div_unit_pkg.sv
// Shared types for the iterative divider: FSM state encoding and divide-by-zero quotient fill.
package iter_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } divState_e;

    // Every quotient bit takes this value when the divisor is zero.
    localparam logic DIV_ZERO_QUO_BIT = 1'b1;

endpackage

// File: rtl/iter_div_unit_if.sv
// Issue/result bundle between the execute stage, hazard unit and the iterative divider.
interface iter_div_unit_if #(parameter int WIDTH = 32);

    logic             start_e;
    logic             is_signed_e;
    logic [WIDTH-1:0] dividend_e;
    logic [WIDTH-1:0] divisor_e;
    logic             flush;
    logic             mf_read_d;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic             div_by_zero;
    logic             stall_req;

    modport master (
        output start_e, is_signed_e, dividend_e, divisor_e, flush, mf_read_d,
        input  busy, done, div_hi, div_lo, div_by_zero, stall_req
    );

    modport slave (
        input  start_e, is_signed_e, dividend_e, divisor_e, flush, mf_read_d,
        output busy, done, div_hi, div_lo, div_by_zero, stall_req
    );

endinterface

// File: rtl/iter_div_unit_step.sv
// One restoring-division iteration: shift next dividend bit into the remainder, trial subtract.
module iter_div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    // remIn < divisor always holds, so trial < 2*divisor and the borrow bit alone decides.
    assign trial  = {remIn, quoIn[WIDTH-1]};
    assign diff   = trial - {1'b0, divisor};
    assign fits   = ~diff[WIDTH];
    assign remOut = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quoOut = {quoIn[WIDTH-2:0], fits};

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle DIV/DIVU unit beside EX: one quotient bit per cycle, sign fixup, HI/LO result regs.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    iter_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    divState_e        state, nextState;
    logic             accept;
    logic [WIDTH-1:0] remReg, quoReg, divisorReg;
    logic [WIDTH-1:0] stepRem, stepQuo;
    logic [WIDTH-1:0] absDividend, absDivisor;
    logic [WIDTH-1:0] divHiReg, divLoReg;
    logic             divByZeroReg;
    logic             negQuo, negRem, opZero;
    logic             dividendNeg, divisorNeg, divisorZero;
    logic [CNT_W-1:0] cnt;

    assign dividendNeg = bus.is_signed_e & bus.dividend_e[WIDTH-1];
    assign divisorNeg  = bus.is_signed_e & bus.divisor_e[WIDTH-1];
    assign divisorZero = (bus.divisor_e == '0);
    assign absDividend = dividendNeg ? -bus.dividend_e : bus.dividend_e;
    assign absDivisor  = divisorNeg ? -bus.divisor_e : bus.divisor_e;

    iter_div_unit_step #(.WIDTH(WIDTH)) uStep (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorReg),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                nextState = IDLE;
                if (bus.start_e) begin
                    accept    = 1'b1;
                    nextState = divisorZero ? FIXUP : CALC;
                end
            end
            CALC:    if (cnt == CNT_W'(1)) nextState = FIXUP;
            FIXUP:   nextState = DONE;
            default: nextState = IDLE;
        endcase
        if (bus.flush) begin
            nextState = IDLE;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remReg       <= '0;
            quoReg       <= '0;
            divisorReg   <= '0;
            negQuo       <= 1'b0;
            negRem       <= 1'b0;
            opZero       <= 1'b0;
            cnt          <= '0;
            divHiReg     <= '0;
            divLoReg     <= '0;
            divByZeroReg <= 1'b0;
        end else if (accept) begin
            remReg       <= '0;
            // A zero divisor keeps the raw dividend here so it can be returned as the remainder.
            quoReg       <= divisorZero ? bus.dividend_e : absDividend;
            divisorReg   <= absDivisor;
            negQuo       <= dividendNeg ^ divisorNeg;
            negRem       <= dividendNeg;
            opZero       <= divisorZero;
            cnt          <= CNT_W'(WIDTH);
            divByZeroReg <= 1'b0;
        end else if (!bus.flush && state == CALC) begin
            remReg <= stepRem;
            quoReg <= stepQuo;
            cnt    <= cnt - CNT_W'(1);
        end else if (!bus.flush && state == FIXUP) begin
            if (opZero) begin
                divLoReg     <= {WIDTH{DIV_ZERO_QUO_BIT}};
                divHiReg     <= quoReg;
                divByZeroReg <= 1'b1;
            end else begin
                divLoReg     <= negQuo ? -quoReg : quoReg;
                divHiReg     <= negRem ? -remReg : remReg;
                divByZeroReg <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state == CALC) || (state == FIXUP);
    assign bus.done        = (state == DONE);
    assign bus.div_hi      = divHiReg;
    assign bus.div_lo      = divLoReg;
    assign bus.div_by_zero = divByZeroReg;
    assign bus.stall_req   = bus.mf_read_d & (bus.busy | bus.start_e);

endmodule

// File: tb/tb_iter_div_unit.sv
// Scoreboard bench for iter_div_unit: directed corner cases, flush/reset, stall and random back-to-back ops.
module tb_iter_div_unit;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dz;
    } divExp_t;

    logic    clock = 1'b0;
    logic    reset = 1'b1;
    int      cyc = 0;
    int      nCompared = 0;
    int      nMismatched = 0;
    int      doneCount = 0;
    int      lastDoneCyc = 0;
    divExp_t sbQ[$];

    iter_div_unit_if #(.WIDTH(WIDTH)) bus ();

    iter_div_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic divExp_t refDiv(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        divExp_t r;
        longint  sa, sb;
        if (b == '0) begin
            r.lo = '1;
            r.hi = a;
            r.dz = 1'b1;
        end else if (sgn) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            r.lo = WIDTH'(sa / sb);
            r.hi = WIDTH'(sa % sb);
            r.dz = 1'b0;
        end else begin
            r.lo = a / b;
            r.hi = a % b;
            r.dz = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (!reset && bus.done) begin
            divExp_t e;
            doneCount++;
            lastDoneCyc = cyc;
            if (sbQ.size() == 0) begin
                checkVal("unexpected_done", 64'(doneCount), 64'(doneCount - 1));
            end else begin
                e = sbQ.pop_front();
                checkVal("div_lo", 64'(bus.div_lo), 64'(e.lo));
                checkVal("div_hi", 64'(bus.div_hi), 64'(e.hi));
                checkVal("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
            end
        end
    end

    // Drives start for one cycle from the current point; the next posedge accepts it.
    task automatic issueDiv(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit expectDone, output int startCyc);
        bus.start_e     = 1'b1;
        bus.is_signed_e = sgn;
        bus.dividend_e  = a;
        bus.divisor_e   = b;
        startCyc        = cyc;
        if (expectDone) sbQ.push_back(refDiv(sgn, a, b));
        @(posedge clock);
        #1;
        bus.start_e = 1'b0;
    endtask

    task automatic waitDone(input int prev, input string tag);
        for (int i = 0; i < 100 && doneCount == prev; i++) begin
            @(negedge clock);
            #1;
        end
        checkVal(tag, 64'(doneCount - prev), 64'd1);
    endtask

    task automatic toCycle(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic runOp(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int expLat, input string tag);
        int sc, prev;
        @(posedge clock);
        #1;
        prev = doneCount;
        issueDiv(sgn, a, b, 1'b1, sc);
        waitDone(prev, {tag, "_timeout"});
        checkVal({tag, "_latency"}, 64'(lastDoneCyc - sc), 64'(expLat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, prev;
        logic sgn;
        logic [WIDTH-1:0] a, b;

        bus.start_e     = 1'b0;
        bus.is_signed_e = 1'b0;
        bus.dividend_e  = '0;
        bus.divisor_e   = '0;
        bus.flush       = 1'b0;
        bus.mf_read_d   = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        checkVal("rst_busy", 64'(bus.busy), 64'd0);
        checkVal("rst_done", 64'(bus.done), 64'd0);
        checkVal("rst_hi", 64'(bus.div_hi), 64'd0);
        checkVal("rst_lo", 64'(bus.div_lo), 64'd0);
        checkVal("rst_dz", 64'(bus.div_by_zero), 64'd0);
        reset = 1'b0;

        runOp(1'b0, 32'd100, 32'd7, WIDTH + 2, "divu_100_7");
        runOp(1'b1, 32'hFFFF_FFF9, 32'h2, WIDTH + 2, "div_m7_2");
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, WIDTH + 2, "div_ovf");
        runOp(1'b0, 32'd5, 32'd0, 2, "divu_by_zero");
        runOp(1'b0, 32'd9, 32'd3, WIDTH + 2, "divu_9_3");

        // Flush mid-calculation: no done, results held.
        @(posedge clock);
        #1;
        issueDiv(1'b0, 32'd50, 32'd5, 1'b0, sc);
        toCycle(sc + 10);
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        @(negedge clock);
        checkVal("flush_busy", 64'(bus.busy), 64'd0);
        prev = doneCount;
        repeat (40) @(negedge clock);
        checkVal("flush_no_done", 64'(doneCount - prev), 64'd0);
        checkVal("flush_keep_lo", 64'(bus.div_lo), 64'd3);
        checkVal("flush_keep_hi", 64'(bus.div_hi), 64'd0);

        // Flush and start together: nothing accepted.
        @(posedge clock);
        #1;
        bus.start_e    = 1'b1;
        bus.flush      = 1'b1;
        bus.dividend_e = 32'd8;
        bus.divisor_e  = 32'd2;
        @(posedge clock);
        #1;
        bus.start_e = 1'b0;
        bus.flush   = 1'b0;
        @(negedge clock);
        checkVal("flush_start_busy", 64'(bus.busy), 64'd0);
        prev = doneCount;
        repeat (40) @(negedge clock);
        checkVal("flush_start_no_done", 64'(doneCount - prev), 64'd0);
        checkVal("flush_start_keep_lo", 64'(bus.div_lo), 64'd3);

        // Stall request while decode holds MFHI/MFLO.
        @(posedge clock);
        #1;
        prev = doneCount;
        issueDiv(1'b0, 32'd1000, 32'd3, 1'b1, sc);
        bus.mf_read_d = 1'b1;
        for (int k = 1; k <= WIDTH + 2; k++) begin
            toCycle(sc + k);
            @(negedge clock);
            checkVal($sformatf("stall_req_c%0d", k), 64'(bus.stall_req), 64'(k <= WIDTH + 1));
        end
        bus.mf_read_d = 1'b0;
        waitDone(prev, "stall_op_timeout");

        // Asynchronous reset between edges mid-CALC.
        @(posedge clock);
        #1;
        issueDiv(1'b0, 32'd12345, 32'd7, 1'b0, sc);
        toCycle(sc + 15);
        @(negedge clock);
        checkVal("pre_rst_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        checkVal("arst_busy", 64'(bus.busy), 64'd0);
        checkVal("arst_done", 64'(bus.done), 64'd0);
        checkVal("arst_hi", 64'(bus.div_hi), 64'd0);
        checkVal("arst_lo", 64'(bus.div_lo), 64'd0);
        checkVal("arst_dz", 64'(bus.div_by_zero), 64'd0);
        #2;
        reset = 1'b0;
        prev = doneCount;
        repeat (40) @(negedge clock);
        checkVal("arst_no_done", 64'(doneCount - prev), 64'd0);

        // Random regression, each new op issued in the previous op's done cycle.
        @(posedge clock);
        #1;
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i == 5) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            issueDiv(sgn, a, b, 1'b1, sc);
            prev = doneCount;
            waitDone(prev, $sformatf("rand%0d_timeout", i));
            checkVal($sformatf("rand%0d_latency", i), 64'(lastDoneCyc - sc),
                     64'((b == '0) ? 2 : WIDTH + 2));
        end

        repeat (3) @(negedge clock);
        checkVal("sb_empty", 64'(sbQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
